nano2_bus_responder: RTL

Memory-mapped responder sitting on the nano2 core's word-addressed read/write/waitrequest bus. It serves the core's fetch, load/store and stack traffic from an on-chip word RAM, and decodes a small IO window holding a down-counting timer and a general-purpose output register. The timer drives the core's irq input. One responder serves one core; there is no arbitration.

---
 rtl/nano2_bus_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/nano2_bus_responder.sv
// nano2_bus_responder
// Word-addressed bus slave for the nano2 core: on-chip word RAM plus an
// 8-word IO window holding a down-counting timer and a general-purpose
// output register. Reads take exactly one wait state. Writes complete
// with no wait state.
module nano2_bus_responder #(
    parameter int unsigned       WIDTHA   = 12,
    parameter int unsigned       WIDTHD   = 32,
    parameter int unsigned       RAMWORDS = 1024,
    parameter logic [WIDTHA-1:0] IOBASE   = 'hff0
) (
    input  logic              clock,
    input  logic              areset_n,
    input  logic [WIDTHA-1:0] address,
    input  logic [WIDTHD-1:0] writedata,
    output logic [WIDTHD-1:0] readdata,
    input  logic              read,
    input  logic              write,
    output logic              waitrequest,
    output logic              irq,
    output logic [WIDTHD-1:0] gpo
);

    localparam int unsigned       RAM_AW    = $clog2(RAMWORDS);
    localparam logic [WIDTHA:0]   RAM_LIMIT = RAMWORDS[WIDTHA:0];

    typedef enum logic {
        S_IDLE,
        S_RDATA
    } state_t;

    // Which source drives readdata after a completed read
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_IO
    } sel_t;

    state_t              state_q, state_d;
    sel_t                sel_q, sel_d;

    logic [WIDTHD-1:0]   mem_q [RAMWORDS];
    logic [WIDTHD-1:0]   ram_rd_q;
    logic [WIDTHD-1:0]   io_rd_q;
    logic [WIDTHD-1:0]   io_rdata;

    logic                en_q, en_d;
    logic                irq_en_q, irq_en_d;
    logic                auto_q, auto_d;
    logic [WIDTHD-1:0]   load_q, load_d;
    logic [WIDTHD-1:0]   count_q, count_d;
    logic                pending_q, pending_d;
    logic [WIDTHD-1:0]   gpo_q, gpo_d;
    logic                irq_q, irq_d;

    logic                ram_hit;
    logic                io_hit;
    logic [2:0]          io_off;
    logic [RAM_AW-1:0]   ram_idx;
    logic                rd_accept;
    logic                ram_we;
    logic                ctrl_wr, load_wr, count_wr, status_wr, gpo_wr;

    assign ram_hit   = ({1'b0, address} < RAM_LIMIT);
    assign io_hit    = (address[WIDTHA-1:3] == IOBASE[WIDTHA-1:3]);
    assign io_off    = address[2:0];
    assign ram_idx   = address[RAM_AW-1:0];

    // A write alongside a read is served as the write alone
    assign rd_accept   = read & ~write & (state_q == S_IDLE);
    assign waitrequest = rd_accept;

    assign ram_we    = write & ram_hit;
    assign ctrl_wr   = write & io_hit & (io_off == 3'd0);
    assign load_wr   = write & io_hit & (io_off == 3'd1);
    assign count_wr  = write & io_hit & (io_off == 3'd2);
    assign status_wr = write & io_hit & (io_off == 3'd3) & writedata[0];
    assign gpo_wr    = write & io_hit & (io_off == 3'd4);

    assign irq = irq_q;
    assign gpo = gpo_q;

    // IO register read-back mux
    always_comb begin
        io_rdata = '0;
        case (io_off)
            3'd0:    io_rdata = {{(WIDTHD-3){1'b0}}, auto_q, irq_en_q, en_q};
            3'd1:    io_rdata = load_q;
            3'd2:    io_rdata = count_q;
            3'd3:    io_rdata = {{(WIDTHD-1){1'b0}}, pending_q};
            3'd4:    io_rdata = gpo_q;
            default: io_rdata = '0;
        endcase
    end

    // Read FSM: IDLE accepts a read and stalls; RDATA presents the data
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (rd_accept) begin
                    state_d = S_RDATA;
                    if (ram_hit)     sel_d = SEL_RAM;
                    else if (io_hit) sel_d = SEL_IO;
                    else             sel_d = SEL_NONE;
                end
            end
            S_RDATA: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // readdata is a mux of registers loaded only on acceptance, so it holds between reads
    always_comb begin
        readdata = '0;
        case (sel_q)
            SEL_RAM: readdata = ram_rd_q;
            SEL_IO:  readdata = io_rd_q;
            default: readdata = '0;
        endcase
    end

    // Timer, status and GPO next state; software writes override hardware updates
    always_comb begin
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        auto_d    = auto_q;
        load_d    = load_q;
        count_d   = count_q;
        pending_d = pending_q;
        gpo_d     = gpo_q;
        irq_d     = pending_q & irq_en_q;

        if (en_q) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTHD'(1);
            end else begin
                if (auto_q) count_d = load_q;
                else        en_d    = 1'b0;
            end
        end

        if (ctrl_wr) begin
            en_d     = writedata[0];
            irq_en_d = writedata[1];
            auto_d   = writedata[2];
        end
        if (load_wr)  load_d  = writedata;
        if (count_wr) count_d = writedata;
        if (gpo_wr)   gpo_d   = writedata;

        // A hardware expiry wins over a simultaneous write-1-to-clear
        if (en_q && (count_q == '0)) pending_d = 1'b1;
        else if (status_wr)          pending_d = 1'b0;
    end

    // Control and timer state registers
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= S_IDLE;
            sel_q     <= SEL_NONE;
            io_rd_q   <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            auto_q    <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            gpo_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            if (rd_accept && io_hit) io_rd_q <= io_rdata;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            auto_q    <= auto_d;
            load_q    <= load_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            gpo_q     <= gpo_d;
            irq_q     <= irq_d;
        end
    end

    // Word RAM with registered read; contents and read register are not reset
    always_ff @(posedge clock) begin
        if (ram_we)              mem_q[ram_idx] <= writedata;
        if (rd_accept && ram_hit) ram_rd_q      <= mem_q[ram_idx];
    end

endmodule
